membus_dma: RTL and testbench

Word-copy DMA engine that is an initiator on the picorv32 native memory bus (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata). The other blocks on that bus are responders; this block drives the bus itself. It copies a programmed number of 32-bit words from a source address to a destination address, one read then one write per word. It sits on a second bus port of the same address decode as the core and reports completion via a done pulse usable as an IRQ line.

---
 rtl/membus_pkg.sv | 29 ++
 rtl/membus_phase.sv | 57 +++++
 rtl/membus_dma.sv | 137 +++++++++++++
 tb/tb_membus_dma.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/membus_pkg.sv
// Shared types and constants for the membus word-copy DMA.
package membus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_GAP,
        ST_RD,
        ST_WR_GAP,
        ST_WR,
        ST_FIN
    } state_e;

    localparam logic [3:0]  WSTRB_RD  = 4'h0;
    localparam logic [3:0]  WSTRB_WR  = 4'hF;
    localparam logic [31:0] ADDR_STEP = 32'd4;
    localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;

    // One bus request as launched by the engine.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ADDR_MASK;
    endfunction

endpackage

// File: rtl/membus_phase.sv
// Single bus request: holds valid/addr/wdata/wstrb until ready or timeout.
module membus_phase
    import membus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        launch_i,
    input  mem_req_t    req_i,
    input  logic        mem_ready,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        ok_c,
    output logic        timeout_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic             valid_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;
    logic [CNT_W-1:0] cnt_q;

    // Ready in the last allowed cycle still completes the request.
    assign ok_c      = valid_q & mem_ready;
    assign timeout_c = valid_q & ~mem_ready & (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            cnt_q   <= '0;
        end else if (launch_i) begin
            valid_q <= 1'b1;
            addr_q  <= req_i.addr;
            wdata_q <= req_i.wdata;
            wstrb_q <= req_i.wstrb;
            cnt_q   <= '0;
        end else if (ok_c || timeout_c) begin
            valid_q <= 1'b0;
        end else if (valid_q) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign mem_valid = valid_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;

endmodule

// File: rtl/membus_dma.sv
// Word-copy DMA initiator on the picorv32 native memory bus.
module membus_dma
    import membus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned LEN_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] word_cnt,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] xfer_cnt,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_rdata
);

    state_e           state_q;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [31:0]      buf_q;
    logic [LEN_W-1:0] rem_q;
    logic [LEN_W-1:0] xfer_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic             launch_c;
    logic             rd_gap_c;
    logic             ok_c;
    logic             timeout_c;
    mem_req_t         req_c;

    // Gap states launch the next request so valid rises one cycle later.
    assign rd_gap_c = (state_q == ST_RD_GAP);
    assign launch_c = rd_gap_c || (state_q == ST_WR_GAP);
    assign req_c    = '{addr:  rd_gap_c ? src_q : dst_q,
                        wdata: buf_q,
                        wstrb: rd_gap_c ? WSTRB_RD : WSTRB_WR};

    membus_phase #(.TIMEOUT(TIMEOUT)) u_phase (
        .clk       (clk),
        .rst       (rst),
        .launch_i  (launch_c),
        .req_i     (req_c),
        .mem_ready (mem_ready),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .ok_c      (ok_c),
        .timeout_c (timeout_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            buf_q   <= '0;
            rem_q   <= '0;
            xfer_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        src_q  <= word_align(src_addr);
                        dst_q  <= word_align(dst_addr);
                        rem_q  <= word_cnt;
                        err_q  <= 1'b0;
                        xfer_q <= '0;
                        if (word_cnt == '0) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RD_GAP;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_RD_GAP: state_q <= ST_RD;
                ST_RD: begin
                    if (ok_c) begin
                        buf_q   <= mem_rdata;
                        src_q   <= src_q + ADDR_STEP;
                        state_q <= ST_WR_GAP;
                    end else if (timeout_c) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_FIN;
                    end
                end
                ST_WR_GAP: state_q <= ST_WR;
                ST_WR: begin
                    if (ok_c) begin
                        dst_q  <= dst_q + ADDR_STEP;
                        xfer_q <= xfer_q + LEN_W'(1);
                        rem_q  <= rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_FIN;
                        end else begin
                            state_q <= ST_RD_GAP;
                        end
                    end else if (timeout_c) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_FIN;
                    end
                end
                ST_FIN:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign xfer_cnt = xfer_q;

endmodule

// File: tb/tb_membus_dma.sv
// Self-checking bench for membus_dma: vector table plus responder scoreboard.
module tb_membus_dma;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] word_cnt;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] xfer_cnt;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    membus_dma #(.TIMEOUT(TO), .LEN_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .word_cnt  (word_cnt),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .xfer_cnt  (xfer_cnt),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pattern(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Responder memory and scoreboard queues.
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic [31:0] mem_m [logic [31:0]];
    logic [31:0] rq [$];
    wr_t         wq [$];

    int          req_idx   = 0;
    int          hang_idx  = -1;
    int          max_wait  = 0;
    int          hs_cnt    = 0;
    int          last_run  = 0;
    int          run       = 0;
    int          wait_left = 0;
    bit          in_req    = 0;
    bit          hung      = 0;
    bit          last_hs   = 0;
    logic [31:0] la, lw;
    logic [3:0]  ls;
    wr_t         e;

    always @(negedge clk) begin
        mem_ready = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        if (rst) begin
            in_req  = 0;
            last_hs = 0;
        end else if (mem_valid) begin
            if (last_hs) begin
                check("valid_gap", 32'd1, 32'd0);
                in_req = 0;
            end
            if (!in_req) begin
                in_req    = 1;
                la        = mem_addr;
                lw        = mem_wdata;
                ls        = mem_wstrb;
                run       = 0;
                hung      = (req_idx == hang_idx);
                wait_left = int'($urandom_range(max_wait, 0));
                req_idx++;
                check("wstrb_legal", 32'((ls == 4'h0) || (ls == 4'hF)), 32'd1);
                if (ls == 4'h0) begin
                    if (rq.size() == 0) check("rd_expected", 32'd0, 32'd1);
                    else check("rd_addr", la, rq.pop_front());
                end
            end else begin
                check("req_hold", 32'((mem_addr == la) && (mem_wdata == lw) && (mem_wstrb == ls)), 32'd1);
            end
            run++;
            if (!hung && wait_left == 0) begin
                mem_ready = 1'b1;
                hs_cnt++;
                if (ls == 4'h0) begin
                    mem_rdata = mem_m.exists(la) ? mem_m[la] : pattern(la);
                end else begin
                    if (wq.size() == 0) begin
                        check("wr_expected", 32'd0, 32'd1);
                    end else begin
                        e = wq.pop_front();
                        check("wr_addr", la, e.a);
                        check("wr_data", lw, e.d);
                    end
                    mem_m[la] = lw;
                end
            end else if (wait_left > 0) begin
                wait_left--;
            end
        end else begin
            if (in_req) last_run = run;
            in_req = 0;
        end
        last_hs = mem_ready;
    end

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        int          cnt;
        int          maxw;
        int          hang;
        bit          mid;
        int          xfer;
        bit          err;
        int          hs;
        bit          lat;
    } vec_t;

    vec_t tbl [7];

    task automatic run_case(input vec_t v);
        int lat;
        int nrd;
        logic [31:0] s0, d0;
        s0 = v.src & 32'hFFFF_FFFC;
        d0 = v.dst & 32'hFFFF_FFFC;
        req_idx  = 0;
        hang_idx = v.hang;
        max_wait = v.maxw;
        hs_cnt   = 0;
        nrd = (v.hang >= 0) ? v.xfer + 1 : v.cnt;
        for (int i = 0; i < nrd; i++) rq.push_back(s0 + 32'(i) * 32'd4);
        for (int i = 0; i < v.xfer; i++)
            wq.push_back('{a: d0 + 32'(i) * 32'd4, d: pattern(s0 + 32'(i) * 32'd4)});

        @(negedge clk);
        start    = 1'b1;
        src_addr = v.src;
        dst_addr = v.dst;
        word_cnt = 16'(v.cnt);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'(v.cnt != 0));
        check("err_cleared", 32'(err), 32'd0);
        check("xfer_cleared", 32'(xfer_cnt), 32'd0);

        lat = 0;
        while (!done && lat < 3000) begin
            @(posedge clk); #1;
            lat++;
            start = v.mid && (lat == 5);
            if (start) begin
                src_addr = 32'h0000_B000;
                word_cnt = 16'd1;
            end
        end
        start = 1'b0;
        check("done_seen", 32'(done), 32'd1);
        if (v.lat) check("done_cycles", 32'(lat + 2), 32'(4 * v.cnt + 2));
        check("err_at_done", 32'(err), 32'(v.err));
        check("xfer_at_done", 32'(xfer_cnt), 32'(v.xfer));
        check("busy_at_done", 32'(busy), 32'd0);
        check("valid_at_done", 32'(mem_valid), 32'd0);
        @(posedge clk); #1;
        check("done_pulse", 32'(done), 32'd0);
        check("handshakes", 32'(hs_cnt), 32'(v.hs));
        check("rd_queue_empty", 32'(rq.size()), 32'd0);
        check("wr_queue_empty", 32'(wq.size()), 32'd0);
        if (v.hang >= 0) check("timeout_valid_cycles", 32'(last_run), 32'(TO));
        rq.delete();
        wq.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'h0000_1000, 32'h0000_2000, 4,  0,  -1, 1'b0, 4,  1'b0, 8,  1'b1};
        tbl[1] = '{32'h0000_4000, 32'h0000_4100, 0,  0,  -1, 1'b0, 0,  1'b0, 0,  1'b1};
        tbl[2] = '{32'h0000_3000, 32'h0000_5000, 16, 10, -1, 1'b0, 16, 1'b0, 32, 1'b0};
        tbl[3] = '{32'h0000_7000, 32'h0000_8000, 3,  0,  4,  1'b0, 2,  1'b1, 4,  1'b0};
        tbl[4] = '{32'h0000_9000, 32'h0000_A000, 2,  0,  -1, 1'b0, 2,  1'b0, 4,  1'b1};
        tbl[5] = '{32'hFFFF_FFFC, 32'h0000_1003, 2,  0,  -1, 1'b0, 2,  1'b0, 4,  1'b1};
        tbl[6] = '{32'h0000_9100, 32'h0000_A100, 3,  2,  -1, 1'b1, 3,  1'b0, 6,  1'b0};

        rst      = 1'b1;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        word_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", {busy, done, err, mem_valid, mem_wstrb, xfer_cnt}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_case(tbl[i]);

        // Reset while a write is outstanding, then a normal transfer.
        req_idx  = 0;
        hang_idx = 1;
        max_wait = 0;
        rq.push_back(32'h0000_C000);
        @(negedge clk);
        start    = 1'b1;
        src_addr = 32'h0000_C000;
        dst_addr = 32'h0000_D000;
        word_cnt = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        begin
            int k;
            k = 0;
            while (!(mem_valid && mem_wstrb == 4'hF) && k < 50) begin
                @(posedge clk); #1;
                k++;
            end
            check("reached_wr", 32'(mem_valid && mem_wstrb == 4'hF), 32'd1);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("midwr_rst_outputs", {busy, done, err, mem_valid, mem_wstrb, xfer_cnt}, 32'd0);
        check("midwr_rst_addr", mem_addr, 32'd0);
        check("midwr_rst_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        check("midwr_rd_queue", 32'(rq.size()), 32'd0);
        rq.delete();
        wq.delete();
        run_case('{32'h0000_E000, 32'h0000_F000, 2, 0, -1, 1'b0, 2, 1'b0, 4, 1'b1});

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
